// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg                                                              |
// | Shared widths, special register indices and status record type.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cpu_pkg;

  localparam int DATA_W   = 32;
  localparam int TAG_W    = 4;
  localparam int NUM_REGS = 16;
  localparam int AW       = $clog2(NUM_REGS);

  localparam int SP_REG   = 13;
  localparam int SP_INIT  = 28;
  localparam int LINK_REG = 14;
  localparam int LINK_OFS = 8;
  localparam int PC_INIT  = 8;

  // Tag field is sized by the package TAG_W; the top keeps the same width.
  typedef struct packed {
    logic             busy;
    logic [TAG_W-1:0] tag;
  } reg_status_t;

endpackage
`default_nettype wire

// File: rtl/regfile_rd_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_rd_port                                                      |
// | One combinational read port: address mux, zero register, CDB bypass.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module regfile_rd_port
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = cpu_pkg::NUM_REGS,
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int TAG_W    = cpu_pkg::TAG_W,
  parameter int ZERO_REG = 0,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic [AW-1:0]     rd_addr,
  input  logic [DATA_W-1:0] regs [NUM_REGS],
  input  reg_status_t       stat [NUM_REGS],
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_busy,
  output logic [TAG_W-1:0]  rd_tag
);

  reg_status_t       w_stat;
  logic [DATA_W-1:0] w_val;

  always_comb begin
    w_stat = stat[rd_addr];
    w_val  = regs[rd_addr];
    if (ZERO_REG != 0 && rd_addr == '0) begin
      w_stat = '0;
      w_val  = '0;
    end
    rd_data = w_val;
    rd_busy = w_stat.busy;
    rd_tag  = w_stat.tag;
    // A result broadcast this cycle satisfies the pending read immediately.
    if (w_stat.busy && cdb_valid && cdb_tag == w_stat.tag) begin
      rd_data = cdb_data;
      rd_busy = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_tagged.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_tagged                                                       |
// | Register file with busy/tag status, CDB writeback, rename and PC.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module regfile_tagged
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = cpu_pkg::NUM_REGS,
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int TAG_W    = cpu_pkg::TAG_W,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 0,
  parameter int SP_REG   = cpu_pkg::SP_REG,
  parameter int SP_INIT  = cpu_pkg::SP_INIT,
  parameter int LINK_REG = cpu_pkg::LINK_REG,
  parameter int LINK_OFS = cpu_pkg::LINK_OFS,
  parameter int PC_INIT  = cpu_pkg::PC_INIT,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  output logic [NRD*TAG_W-1:0]  rd_tag,
  input  logic                  disp_valid,
  input  logic [AW-1:0]         disp_rd,
  input  logic [TAG_W-1:0]      disp_tag,
  input  logic                  cdb_valid,
  input  logic [TAG_W-1:0]      cdb_tag,
  input  logic [DATA_W-1:0]     cdb_data,
  input  logic                  flush,
  input  logic                  pc_we,
  input  logic [DATA_W-1:0]     pc_next,
  input  logic                  link_we,
  output logic [DATA_W-1:0]     pc_out
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  reg_status_t       r_stat [NUM_REGS];
  logic [DATA_W-1:0] r_pc;

  assign pc_out = r_pc;

  // Later assignments in the loop body override earlier ones:
  // CDB < dispatch < flush (busy only) < link.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= (i == SP_REG) ? DATA_W'(SP_INIT) : '0;
        r_stat[i] <= '0;
      end
      r_pc <= DATA_W'(PC_INIT);
    end else begin
      if (pc_we) begin
        r_pc <= pc_next;
      end
      for (int i = 0; i < NUM_REGS; i++) begin
        if (ZERO_REG == 0 || i != 0) begin
          if (cdb_valid && r_stat[i].busy && r_stat[i].tag == cdb_tag) begin
            r_regs[i]      <= cdb_data;
            r_stat[i].busy <= 1'b0;
          end
          if (disp_valid && !flush && disp_rd == AW'(i)) begin
            r_stat[i].busy <= 1'b1;
            r_stat[i].tag  <= disp_tag;
          end
          if (flush) begin
            r_stat[i].busy <= 1'b0;
          end
          if (link_we && i == LINK_REG) begin
            r_regs[i]      <= r_pc + DATA_W'(LINK_OFS);
            r_stat[i].busy <= 1'b0;
          end
        end
      end
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd_port
    regfile_rd_port #(
      .NUM_REGS (NUM_REGS),
      .DATA_W   (DATA_W),
      .TAG_W    (TAG_W),
      .ZERO_REG (ZERO_REG)
    ) u_rd_port (
      .rd_addr   (rd_addr[p*AW +: AW]),
      .regs      (r_regs),
      .stat      (r_stat),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .rd_data   (rd_data[p*DATA_W +: DATA_W]),
      .rd_busy   (rd_busy[p]),
      .rd_tag    (rd_tag[p*TAG_W +: TAG_W])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_tagged.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_regfile_tagged                                                    |
// | Directed table plus randomized run against a reference model.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_regfile_tagged;

  logic        clk = 1'b0;
  logic        Reset;
  logic [7:0]  rd_addr;
  logic        disp_valid, cdb_valid, flush, pc_we, link_we;
  logic [3:0]  disp_rd, disp_tag, cdb_tag;
  logic [31:0] cdb_data, pc_next;

  logic [63:0] rdd0, rdd1;
  logic [1:0]  rdb0, rdb1;
  logic [7:0]  rdt0, rdt1;
  logic [31:0] pc0, pc1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_tagged #(.ZERO_REG(0)) dut0 (
    .clk(clk), .Reset(Reset), .rd_addr(rd_addr), .rd_data(rdd0), .rd_busy(rdb0),
    .rd_tag(rdt0), .disp_valid(disp_valid), .disp_rd(disp_rd), .disp_tag(disp_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .flush(flush),
    .pc_we(pc_we), .pc_next(pc_next), .link_we(link_we), .pc_out(pc0));

  regfile_tagged #(.ZERO_REG(1)) dut1 (
    .clk(clk), .Reset(Reset), .rd_addr(rd_addr), .rd_data(rdd1), .rd_busy(rdb1),
    .rd_tag(rdt1), .disp_valid(disp_valid), .disp_rd(disp_rd), .disp_tag(disp_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .flush(flush),
    .pc_we(pc_we), .pc_next(pc_next), .link_we(link_we), .pc_out(pc1));

  // Reference state: index 0 models ZERO_REG=0, index 1 models ZERO_REG=1.
  logic [31:0] m_reg  [2][16];
  logic        m_busy [2][16];
  logic [3:0]  m_tag  [2][16];
  logic [31:0] m_pc;

  function automatic void model_reset();
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 16; r++) begin
        m_reg[d][r]  = (r == 13) ? 32'd28 : 32'd0;
        m_busy[d][r] = 1'b0;
        m_tag[d][r]  = 4'd0;
      end
    m_pc = 32'd8;
  endfunction

  function automatic void model_step();
    logic [31:0] nreg [16];
    logic        nbusy [16];
    logic [3:0]  ntag [16];
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 16; r++) begin
        nreg[r] = m_reg[d][r]; nbusy[r] = m_busy[d][r]; ntag[r] = m_tag[d][r];
        if (cdb_valid && m_busy[d][r] && m_tag[d][r] == cdb_tag) begin
          nreg[r] = cdb_data; nbusy[r] = 1'b0;
        end
        if (flush) nbusy[r] = 1'b0;
      end
      if (disp_valid && !flush) begin
        nbusy[disp_rd] = 1'b1; ntag[disp_rd] = disp_tag;
      end
      if (link_we) begin
        nreg[14] = m_pc + 32'd8; nbusy[14] = 1'b0;
      end
      if (d == 1) begin
        nreg[0] = 32'd0; nbusy[0] = 1'b0; ntag[0] = 4'd0;
      end
      for (int r = 0; r < 16; r++) begin
        m_reg[d][r] = nreg[r]; m_busy[d][r] = nbusy[r]; m_tag[d][r] = ntag[r];
      end
    end
    if (pc_we) m_pc = pc_next;
  endfunction

  function automatic void exp_read(input int d, input int a, output logic [31:0] data,
                                   output logic busy, output logic [3:0] tag);
    data = m_reg[d][a]; busy = m_busy[d][a]; tag = m_tag[d][a];
    if (busy && cdb_valid && cdb_tag == tag) begin
      data = cdb_data; busy = 1'b0;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tagname);
    logic [31:0] ed; logic eb; logic [3:0] et; int a;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        a = int'(rd_addr[p*4 +: 4]);
        exp_read(d, a, ed, eb, et);
        chk($sformatf("%s_d%0d_p%0d_r%0d_data", tagname, d, p, a),
            (d == 0) ? rdd0[p*32 +: 32] : rdd1[p*32 +: 32], ed);
        chk($sformatf("%s_d%0d_p%0d_r%0d_busy", tagname, d, p, a),
            32'((d == 0) ? rdb0[p] : rdb1[p]), 32'(eb));
        if (eb)
          chk($sformatf("%s_d%0d_p%0d_r%0d_tag", tagname, d, p, a),
              32'((d == 0) ? rdt0[p*4 +: 4] : rdt1[p*4 +: 4]), 32'(et));
      end
      chk($sformatf("%s_d%0d_pc", tagname, d), (d == 0) ? pc0 : pc1, m_pc);
    end
  endtask

  task automatic tick(input string tagname);
    @(negedge clk);
    check_all(tagname);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    disp_valid = 0; disp_rd = 0; disp_tag = 0; cdb_valid = 0; cdb_tag = 0;
    cdb_data = 0; flush = 0; pc_we = 0; pc_next = 0; link_we = 0;
  endtask

  typedef struct {
    logic        dv; logic [3:0] drd; logic [3:0] dtag;
    logic        cv; logic [3:0] ctag; logic [31:0] cdata;
    logic        fl; logic pwe; logic [31:0] pnext; logic lwe;
    logic [3:0]  a0; logic [3:0] a1;
    logic [31:0] e_data; logic e_busy; logic [3:0] e_tag; logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic dv, input logic [3:0] drd, input logic [3:0] dtag,
                     input logic cv, input logic [3:0] ctag, input logic [31:0] cdata,
                     input logic fl, input logic pwe, input logic [31:0] pnext, input logic lwe,
                     input logic [3:0] a0, input logic [3:0] a1,
                     input logic [31:0] ed, input logic eb, input logic [3:0] et,
                     input logic [31:0] ep);
    vec_t v;
    v.dv = dv; v.drd = drd; v.dtag = dtag; v.cv = cv; v.ctag = ctag; v.cdata = cdata;
    v.fl = fl; v.pwe = pwe; v.pnext = pnext; v.lwe = lwe; v.a0 = a0; v.a1 = a1;
    v.e_data = ed; v.e_busy = eb; v.e_tag = et; v.e_pc = ep;
    vecs.push_back(v);
  endtask

  initial begin
    // Expected columns describe port 0 of the ZERO_REG=0 instance, pre-edge.
    //   dv drd dtag cv ctag cdata          fl pwe pnext     lwe a0 a1  e_data         eb et e_pc
    add(0, 0, 0,   0, 0, 32'h0,         0, 0, 32'h0,   0, 13, 0,  32'd28,        0, 0, 32'h8);
    add(1, 5, 3,   0, 0, 32'h0,         0, 0, 32'h0,   0, 5,  13, 32'h0,         0, 0, 32'h8);
    add(0, 0, 0,   0, 0, 32'h0,         0, 0, 32'h0,   0, 5,  1,  32'h0,         1, 3, 32'h8);
    add(0, 0, 0,   1, 3, 32'hDEADBEEF,  0, 0, 32'h0,   0, 5,  5,  32'hDEADBEEF,  0, 0, 32'h8);
    add(0, 0, 0,   0, 0, 32'h0,         0, 0, 32'h0,   0, 5,  4,  32'hDEADBEEF,  0, 0, 32'h8);
    add(1, 5, 3,   0, 0, 32'h0,         0, 0, 32'h0,   0, 5,  0,  32'hDEADBEEF,  0, 0, 32'h8);
    add(1, 5, 7,   0, 0, 32'h0,         0, 0, 32'h0,   0, 5,  0,  32'hDEADBEEF,  1, 3, 32'h8);
    add(0, 0, 0,   1, 3, 32'h11,        0, 0, 32'h0,   0, 5,  0,  32'hDEADBEEF,  1, 7, 32'h8);
    add(0, 0, 0,   1, 7, 32'h22,        0, 0, 32'h0,   0, 5,  0,  32'h22,        0, 0, 32'h8);
    add(0, 0, 0,   0, 0, 32'h0,         0, 0, 32'h0,   0, 5,  0,  32'h22,        0, 0, 32'h8);
    add(1, 2, 1,   0, 0, 32'h0,         0, 0, 32'h0,   0, 2,  0,  32'h0,         0, 0, 32'h8);
    add(1, 2, 4,   1, 1, 32'h55,        0, 0, 32'h0,   0, 2,  0,  32'h55,        0, 0, 32'h8);
    add(0, 0, 0,   0, 0, 32'h0,         0, 0, 32'h0,   0, 2,  5,  32'h55,        1, 4, 32'h8);
    add(1, 1, 5,   0, 0, 32'h0,         0, 0, 32'h0,   0, 1,  2,  32'h0,         0, 0, 32'h8);
    add(1, 3, 6,   0, 0, 32'h0,         0, 0, 32'h0,   0, 2,  1,  32'h55,        1, 4, 32'h8);
    add(1, 4, 9,   0, 0, 32'h0,         1, 0, 32'h0,   0, 3,  4,  32'h0,         1, 6, 32'h8);
    add(0, 0, 0,   0, 0, 32'h0,         0, 0, 32'h0,   0, 4,  2,  32'h0,         0, 0, 32'h8);
    add(0, 0, 0,   0, 0, 32'h0,         0, 0, 32'h0,   0, 1,  3,  32'h0,         0, 0, 32'h8);
    add(0, 0, 0,   0, 0, 32'h0,         0, 1, 32'h100, 0, 14, 2,  32'h0,         0, 0, 32'h8);
    add(0, 0, 0,   0, 0, 32'h0,         0, 1, 32'h200, 1, 14, 0,  32'h0,         0, 0, 32'h100);
    add(0, 0, 0,   0, 0, 32'h0,         0, 0, 32'h0,   0, 14, 0,  32'h108,       0, 0, 32'h200);
    add(1, 0, 2,   0, 0, 32'h0,         0, 0, 32'h0,   0, 0,  14, 32'h0,         0, 0, 32'h200);
    add(0, 0, 0,   0, 0, 32'h0,         0, 0, 32'h0,   0, 0,  1,  32'h0,         1, 2, 32'h200);
    add(0, 0, 0,   1, 2, 32'h77,        0, 0, 32'h0,   0, 0,  0,  32'h77,        0, 0, 32'h200);
    add(0, 0, 0,   0, 0, 32'h0,         0, 0, 32'h0,   0, 0,  5,  32'h77,        0, 0, 32'h200);

    // Reset state, observed both while held and after release.
    Reset = 1'b0; rd_addr = 0; idle();
    model_reset();
    #12;
    for (int r = 0; r < 16; r++) begin
      rd_addr = {4'((r + 1) % 16), 4'(r)};
      #1 check_all("rst_hold");
    end
    Reset = 1'b1;
    for (int r = 0; r < 16; r++) begin
      rd_addr = {4'((r + 7) % 16), 4'(r)};
      #1 check_all("rst_rel");
    end
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      disp_valid = vecs[i].dv; disp_rd = vecs[i].drd; disp_tag = vecs[i].dtag;
      cdb_valid = vecs[i].cv; cdb_tag = vecs[i].ctag; cdb_data = vecs[i].cdata;
      flush = vecs[i].fl; pc_we = vecs[i].pwe; pc_next = vecs[i].pnext;
      link_we = vecs[i].lwe; rd_addr = {vecs[i].a1, vecs[i].a0};
      @(negedge clk);
      chk($sformatf("vec%0d_data", i), rdd0[31:0], vecs[i].e_data);
      chk($sformatf("vec%0d_busy", i), 32'(rdb0[0]), 32'(vecs[i].e_busy));
      if (vecs[i].e_busy) chk($sformatf("vec%0d_tag", i), 32'(rdt0[3:0]), 32'(vecs[i].e_tag));
      chk($sformatf("vec%0d_pc", i), pc0, vecs[i].e_pc);
      check_all($sformatf("vec%0d", i));
      @(posedge clk);
      model_step();
      #1;
    end
    idle();
    @(negedge clk);
    chk("zr_r0_data", rdd1[31:0], 32'h0);
    chk("zr_r0_busy", 32'(rdb1[0]), 32'h0);

    // Randomized traffic; CDB tags are usually drawn from live tags to hit matches.
    for (int c = 0; c < 400; c++) begin
      disp_valid = ($urandom_range(0, 99) < 45);
      disp_rd    = 4'($urandom_range(0, 15));
      disp_tag   = 4'($urandom_range(0, 15));
      cdb_valid  = ($urandom_range(0, 99) < 55);
      cdb_tag    = ($urandom_range(0, 3) != 0) ? m_tag[0][$urandom_range(0, 15)]
                                               : 4'($urandom_range(0, 15));
      cdb_data   = $urandom;
      flush      = ($urandom_range(0, 99) < 5);
      pc_we      = ($urandom_range(0, 99) < 20);
      pc_next    = $urandom;
      link_we    = ($urandom_range(0, 99) < 10);
      rd_addr    = 8'($urandom);
      tick("rnd");
    end

    // Mid-run reset while R3 is pending.
    idle();
    disp_valid = 1; disp_rd = 3; disp_tag = 5; rd_addr = 8'h43;
    tick("pre_mid");
    idle();
    #1 check_all("mid_busy");
    chk("mid_busy_set", 32'(rdb0[0]), 32'h1);
    Reset = 1'b0;
    model_reset();
    #1 check_all("mid_rst");
    chk("mid_rst_busy", 32'(rdb0[0]), 32'h0);
    chk("mid_rst_pc", pc0, 32'h8);
    Reset = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      rd_addr = 8'($urandom);
      tick("post_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
